// File: rtl/recvword_pkg.sv
// Shared types and frame constants for the serial word receiver.
package recvword_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_FLUSH
  } state_t;

  // Line frame: one start bit, DATA_BITS data bits (MSB first), one stop bit.
  localparam logic        START_BIT = 1'b1;
  localparam logic        STOP_BIT  = 1'b0;
  localparam int unsigned DATA_BITS = 2;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);

endpackage : recvword_pkg

// File: rtl/recvword_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync2

// File: rtl/recvword.sv
// Serial word receiver: decodes start/d1/d0/stop frames from a single line,
// samples each bit at its midpoint and reports the word or a framing error.
module recvword
  import recvword_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = $clog2(BIT_CYCLES)
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       line,
  output logic [1:0] word,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DATA_BITS - 1);

  state_t               state, state_next;
  logic                 ls, ls_q;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [1:0]           word_next;
  logic                 valid_next, err_next;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (sysclk),
    .rst_n (rst_n),
    .d     (line),
    .q     (ls)
  );

  assign busy = (state != ST_IDLE);

  // FSM state register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: edge-detect copy, bit timer, data shifter and outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ls_q      <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      word      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ls_q      <= ls;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shreg     <= shreg_next;
      word      <= word_next;
      valid     <= valid_next;
      frame_err <= err_next;
    end
  end

  // Next-state and datapath update; each bit is sampled when the timer hits 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    word_next  = word;
    valid_next = 1'b0;
    err_next   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (ls == START_BIT && ls_q != START_BIT) begin
          cnt_next   = HALF_LOAD;
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (ls == START_BIT) begin
          cnt_next   = FULL_LOAD;
          idx_next   = IDX_TOP;
          state_next = ST_DATA;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          shreg_next[idx] = ls;
          cnt_next        = FULL_LOAD;
          if (idx == '0) begin
            state_next = ST_STOP;
          end else begin
            idx_next = idx - 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (ls == STOP_BIT) begin
          word_next  = shreg;
          valid_next = 1'b1;
          state_next = ST_IDLE;
        end else begin
          err_next   = 1'b1;
          state_next = ST_FLUSH;
        end
      end

      // A stuck-high line must fall before another start can be recognised.
      ST_FLUSH: begin
        if (ls == STOP_BIT) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule : recvword

// File: tb/tb_recvword.sv
// Directed bench for recvword with BIT_CYCLES = 8 (32-cycle frames).
module tb_recvword;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       line   = 1'b0;
  logic [1:0] word;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  recvword #(.BIT_CYCLES(8)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .line      (line),
    .word      (word),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [1:0]  data;
    logic        stop_v;
    int unsigned gap;
    int unsigned extra;
    logic [1:0]  exp_word;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge sysclk); #1 line = 1'b0;
      @(negedge sysclk);
    end
  endtask

  // Line set 1 ns after posedge c0 (k=0); E = c0+3, stop sample at c0+31,
  // so pulses appear at the negedge of iteration k=31.
  task automatic run_frame(input string name, input logic [1:0] d, input logic stop_v,
                           input int unsigned gap, input int unsigned extra,
                           input logic [1:0] exp_word, input logic exp_valid,
                           input logic exp_err);
    logic [3:0] bits;
    logic       stray;
    logic       busy_drop;
    logic       b2;
    logic       b3;
    bits      = {1'b1, d[1], d[0], stop_v};
    stray     = 1'b0;
    busy_drop = 1'b0;
    b2        = 1'b0;
    b3        = 1'b0;
    idle_cycles(gap);
    for (int k = 0; k < 32; k++) begin
      @(posedge sysclk); #1 line = bits[3 - k / 8];
      @(negedge sysclk);
      if (k == 16) check({name, " busy_mid"}, 8'(busy), 8'd1);
      if (k == 31) begin
        check({name, " valid"}, 8'(valid), 8'(exp_valid));
        check({name, " frame_err"}, 8'(frame_err), 8'(exp_err));
        check({name, " word"}, 8'(word), 8'(exp_word));
        check({name, " busy_end"}, 8'(busy), 8'(!exp_valid));
      end else if (valid || frame_err) begin
        stray = 1'b1;
      end
    end
    if (stop_v) begin
      for (int unsigned e = 0; e < extra; e++) begin
        @(posedge sysclk); #1 line = 1'b1;
        @(negedge sysclk);
        if (valid || frame_err) stray = 1'b1;
        if (!busy) busy_drop = 1'b1;
      end
      check({name, " busy_held"}, 8'(busy_drop), 8'd0);
      for (int j = 0; j < 4; j++) begin
        @(posedge sysclk); #1 line = 1'b0;
        @(negedge sysclk);
        if (valid || frame_err) stray = 1'b1;
        if (j == 2) b2 = busy;
        if (j == 3) b3 = busy;
      end
      check({name, " busy_before_fall"}, 8'(b2), 8'd1);
      check({name, " busy_fall"}, 8'(b3), 8'd0);
    end
    check({name, " no_stray_pulse"}, 8'(stray), 8'd0);
  endtask

  initial begin
    logic       stray;
    logic       busy_seen;
    logic [3:0] bits;

    vecs[0] = '{data: 2'b10, stop_v: 1'b0, gap: 6, extra: 0, exp_word: 2'b10, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 2'b00, stop_v: 1'b0, gap: 0, extra: 0, exp_word: 2'b00, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 2'b01, stop_v: 1'b0, gap: 0, extra: 0, exp_word: 2'b01, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 2'b10, stop_v: 1'b0, gap: 0, extra: 0, exp_word: 2'b10, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 2'b11, stop_v: 1'b0, gap: 0, extra: 0, exp_word: 2'b11, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[5] = '{data: 2'b01, stop_v: 1'b1, gap: 0, extra: 12, exp_word: 2'b11, exp_valid: 1'b0, exp_err: 1'b1};
    vecs[6] = '{data: 2'b01, stop_v: 1'b0, gap: 4, extra: 0, exp_word: 2'b01, exp_valid: 1'b1, exp_err: 1'b0};

    // Reset state.
    repeat (3) @(negedge sysclk);
    check("reset word", 8'(word), 8'd0);
    check("reset valid", 8'(valid), 8'd0);
    check("reset frame_err", 8'(frame_err), 8'd0);
    check("reset busy", 8'(busy), 8'd0);
    rst_n = 1'b1;

    // Table: one frame, four back-to-back frames, bad stop bit, recovery frame.
    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_v, vecs[i].gap,
                vecs[i].extra, vecs[i].exp_word, vecs[i].exp_valid, vecs[i].exp_err);
    end

    // Two-cycle glitch: line high after posedges c0, c0+1; E = c0+3, back to IDLE at c0+7.
    idle_cycles(4);
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge sysclk); #1 line = (k < 2);
      @(negedge sysclk);
      if (valid || frame_err) stray = 1'b1;
      if (k == 2) check("glitch busy_before_E", 8'(busy), 8'd0);
      if (k == 3) check("glitch busy_after_E", 8'(busy), 8'd1);
      if (k == 6) check("glitch busy_held", 8'(busy), 8'd1);
      if (k == 7) check("glitch back_idle", 8'(busy), 8'd0);
    end
    check("glitch no_pulse", 8'(stray), 8'd0);
    check("glitch word", 8'(word), 8'd1);

    // Reset asserted inside the d0 bit of a 2'b11 frame, line high at release.
    bits = 4'b1110;
    for (int k = 0; k < 20; k++) begin
      @(posedge sysclk); #1 line = bits[3 - k / 8];
      @(negedge sysclk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst word", 8'(word), 8'd0);
    check("midrst valid", 8'(valid), 8'd0);
    check("midrst frame_err", 8'(frame_err), 8'd0);
    check("midrst busy", 8'(busy), 8'd0);
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    stray = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge sysclk); #1 line = (k < 6);
      @(negedge sysclk);
      if (valid || frame_err) stray = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    check("midrst no_pulse", 8'(stray), 8'd0);
    check("midrst no_start", 8'(busy_seen), 8'd0);
    run_frame("after_midrst", 2'b11, 1'b0, 4, 0, 2'b11, 1'b1, 1'b0);

    // Line held high through reset and after release: not a start.
    @(negedge sysclk);
    rst_n = 1'b0;
    line  = 1'b1;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge sysclk); #1 line = 1'b1;
      @(negedge sysclk);
      if (busy) busy_seen = 1'b1;
      if (valid || frame_err) stray = 1'b1;
    end
    check("highrst no_start", 8'(busy_seen), 8'd0);
    check("highrst no_pulse", 8'(stray), 8'd0);
    check("highrst word", 8'(word), 8'd0);
    run_frame("after_highrst", 2'b10, 1'b0, 6, 0, 2'b10, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_recvword

// File: doc/recvword.md
# recvword

Serial word receiver: the stage directly downstream of `sendword`. It consumes the single-wire `out` line that `sendword` drives and recovers the 2-bit word it carries. It presents the word with a one-cycle valid strobe and flags malformed frames. It lets a second board, or a loopback on the same board, decode what the switch panel transmits.

## Interface
- `BIT_CYCLES`, default 1_000_000: `sysclk` cycles per line bit; must be even and ≥ 4.
- `CNT_W`, default `$clog2(BIT_CYCLES)`: width of the bit-period counter.
- `sysclk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `line` in 1: serial input, asynchronous to `sysclk`; idle low.
- `word` out 2: last correctly framed word; holds until the next good frame.
- `valid` out 1: one-cycle pulse when `word` updates.
- `frame_err` out 1: one-cycle pulse when the stop bit is bad.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Line frame, each bit `BIT_CYCLES` long: start bit (1), d1 (MSB), d0 (LSB), stop bit (0). Idle is 0.
- `line` passes through a 2-flop synchronizer → `ls`. A registered copy `ls_q` is used for edge detect; `ls_q` resets to 1.
- States:
  - IDLE: on `ls`=1 and `ls_q`=0, load counter = `BIT_CYCLES/2-1` → START.
  - START: counter counts down. At 0: if `ls`=1, load `BIT_CYCLES-1`, bit index = 1 → DATA. Otherwise it is a glitch → IDLE, with no pulse.
  - DATA: at counter 0, shift `ls` into `shreg[idx]` and reload `BIT_CYCLES-1`. After idx 0 → STOP.
  - STOP: at counter 0, sample `ls`:
    - If 0: `word` ← `shreg`, `valid` = 1 → IDLE.
    - If 1: `frame_err` = 1, `word` unchanged → FLUSH.
  - FLUSH: wait for `ls`=0, then → IDLE. This prevents retriggering inside a stuck-high line.
- `valid` and `frame_err` are never high together.
- Rising edges on `line` outside IDLE are ignored; no queueing.
- A new frame may start on the cycle after returning to IDLE (back-to-back frames).

## Timing
- Reset values: `word`=2'b00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, `ls`=`ls_q`=1, counter 0.
- Reset mid-frame aborts immediately with no pulse. After release, a receive requires a fresh low→high on `ls`; a line already high at release is not a start.
- Let edge E be the first edge where `ls`=1 with `ls_q`=0. The samples fall at:
  - start sample: E + `BIT_CYCLES/2`
  - d1: E + `BIT_CYCLES/2` + `BIT_CYCLES`
  - d0: E + `BIT_CYCLES/2` + 2·`BIT_CYCLES`
  - stop: E + `BIT_CYCLES/2` + 3·`BIT_CYCLES`
- `word`, `valid` and `frame_err` are registered on the stop-sample edge and visible in the following cycle.
- Input-pin-to-`ls` latency is 2 cycles.
- `busy` rises on the edge after E. It falls on the stop-sample edge for a good frame, or on the edge after `ls` returns to 0 in FLUSH.
- Counter is unsigned `CNT_W` bits, decrement-to-zero only, never wraps below 0.

## Structure
- Package `recvword_pkg` holds the state enum (IDLE, START, DATA, STOP, FLUSH) and the frame constants: start = 1, stop = 0, 2 data bits.
- Sub-module `sync2`: a 2-flop synchronizer with async active-low reset and a reset-value parameter. Here it is instantiated with reset value 1.
- The FSM, counter and shift register live in `recvword`.

## Test plan
All scenarios use `BIT_CYCLES`=8, with the line driven by a bench serializer and edge E defined as above.
- Frame 1,1,0,0 (word 2'b10) → `valid` for one cycle at E+28, `word`=2'b10, `frame_err` never high.
- Four back-to-back frames for words 00, 01, 10, 11, no idle gap → four `valid` pulses spaced 32 cycles apart, words in order.
- 2-cycle high glitch on an idle line → return to IDLE at E+4, no `valid`, no `frame_err`, `word` unchanged.
- Frame for 2'b01 with the stop bit held high for 20 cycles → `frame_err` pulse at E+28, `word` stays at its previous value, `busy` stays high until the line falls, then the next good frame decodes.
- `rst_n` low during the d0 bit with the line high at release → all outputs at reset values, no `valid`. The next full frame for 2'b11 decodes correctly.
- Line held high through reset → no start detected until the line goes low then high.
